// File: rtl/uart_frame_tx.sv
// Multi-byte UART transmitter: serialises a BYTES*DATA_BITS word into back-to-back frames under valid/ready.
// Optional parity bit is compiled in with `define UART_TX_PARITY_EN (PARITY_ODD selects odd parity).
module uart_frame_tx #(
  parameter int BYTES          = 5,
  parameter int DATA_BITS      = 8,
  parameter int STOP_BITS      = 1,
  parameter int BPS            = 115200,
  parameter int CLK_FRE        = 50_000_000,
  parameter int MSB_BYTE_FIRST = 0,
  parameter int PARITY_ODD     = 0
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [BYTES*DATA_BITS-1:0] tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic                       tx_busy,
  output logic                       tx_done,
  output logic                       uart_txd
);

  localparam int BAUD_RAW = CLK_FRE / BPS;
  localparam int BAUD_CNT = (BAUD_RAW < 2) ? 2 : BAUD_RAW;
  localparam int BW       = $clog2(BAUD_CNT);
  localparam int W        = BYTES * DATA_BITS;
  localparam int IW       = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int DW       = $clog2(DATA_BITS);

  if (BYTES < 1 || BYTES > 16 || DATA_BITS < 5 || DATA_BITS > 8 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_err
    $error("uart_frame_tx: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PAR,
`endif
    STOP
  } state_t;

  state_t          state_q;
  logic [BW-1:0]   baud_q;
  logic [DW-1:0]   bit_q;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    shift_q;
  logic            txd_q;
  logic            done_q;
`ifdef UART_TX_PARITY_EN
  logic            par_q;
`endif
  logic            tick;
  logic [W-1:0]    tx_ord;

  // Reorder characters so character 0 always sits in the low slice; the shifter then runs LSB-first throughout.
  for (genvar c = 0; c < BYTES; c++) begin : g_ord
    localparam int SRC = (MSB_BYTE_FIRST != 0) ? (BYTES - 1 - c) : c;
    assign tx_ord[c*DATA_BITS +: DATA_BITS] = tx_data[SRC*DATA_BITS +: DATA_BITS];
  end

  assign tick = (baud_q == BW'(BAUD_CNT - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      baud_q <= tick ? '0 : baud_q + 1'b1;
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          if (tx_valid) begin
            state_q <= START;
            shift_q <= tx_ord;
            idx_q   <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state_q <= DATA;
            bit_q   <= '0;
            txd_q   <= shift_q[0];
`ifdef UART_TX_PARITY_EN
            par_q   <= (PARITY_ODD != 0);
`endif
          end
        end
        DATA: begin
          if (tick) begin
            shift_q <= shift_q >> 1;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_q ^ shift_q[0];
`endif
            if (bit_q == DW'(DATA_BITS - 1)) begin
              bit_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q <= PAR;
              txd_q   <= par_q ^ shift_q[0];
`else
              state_q <= STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              bit_q <= bit_q + 1'b1;
              txd_q <= shift_q[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PAR: begin
          if (tick) begin
            state_q <= STOP;
            bit_q   <= '0;
            txd_q   <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (bit_q == DW'(STOP_BITS - 1)) begin
              bit_q <= '0;
              // Next character starts immediately: no idle bit inside a transaction.
              if (idx_q == IW'(BYTES - 1)) begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end else begin
                state_q <= START;
                idx_q   <= idx_q + 1'b1;
                txd_q   <= 1'b0;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uart_txd = txd_q;
  assign tx_done  = done_q;
  assign tx_busy  = (state_q != IDLE);
  assign tx_ready = (state_q == IDLE) && !sys_rst;

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Parametrised multi-byte UART transmitter with a valid/ready handshake. It serialises a BYTES-wide word into back-to-back UART frames with configurable data width, stop bits and byte order, plus optional parity. It sits between a producer (sensor packer, test-pattern generator, register dump) and the `uart_txd` pin. It supersedes single-mode byte-burst senders: a producer holds `tx_valid` and waits for `tx_ready` instead of pulsing an enable blind.

## Interface
- `BYTES`, 5: characters per transaction, 1..16.
- `DATA_BITS`, 8: data bits per character, 5..8.
- `STOP_BITS`, 1: stop bits per character, 1 or 2.
- `BPS`, 115200: baud rate.
- `CLK_FRE`, 50_000_000: `sys_clk` frequency in Hz.
- `MSB_BYTE_FIRST`, 0: byte order.
  - 0: character 0 is `tx_data[DATA_BITS-1:0]`.
  - 1: character 0 is the top slice.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity. Used only when `UART_TX_PARITY_EN` is defined.

Ports:
- `sys_clk` in 1: clock. One clock; reset is synchronous and active-high.
- `sys_rst` in 1: synchronous, active-high reset.
- `tx_data` in BYTES*DATA_BITS: payload. Sampled on acceptance.
- `tx_valid` in 1: payload valid.
- `tx_ready` out 1: block idle, accepts `tx_data`.
- `tx_busy` out 1: transaction in progress.
- `tx_done` out 1: one-cycle pulse when the last stop bit completes.
- `uart_txd` out 1: serial line, idle high.

## Operation
- Bit period: `BAUD_CNT = CLK_FRE/BPS` (integer division, truncated), at least 2. A baud counter runs 0..BAUD_CNT-1 and each bit lasts exactly BAUD_CNT cycles.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE→START on `tx_valid && tx_ready`. `tx_data` is latched into a shift register and the byte index is cleared.
  - START→DATA after one bit period.
  - DATA sends DATA_BITS bits, LSB first. Then DATA→PAR if parity is compiled in, otherwise DATA→STOP.
  - PAR→STOP after one bit period.
  - STOP lasts STOP_BITS bit periods. Then it goes to START if the byte index < BYTES-1 (index increments), otherwise to IDLE.
- Line levels: start = 0, stop = 1, IDLE = 1.
- Characters within a transaction are back-to-back. There are no idle bits between a stop bit and the next start bit.
- `tx_ready` = (state == IDLE) && !`sys_rst`. `tx_busy` = !(state == IDLE).
- `tx_valid` while busy is ignored. Data is never queued.
- `tx_data` changes after acceptance have no effect on the frame in flight.
- Reset values: `uart_txd`=1, `tx_busy`=0, `tx_done`=0, state IDLE, all counters 0.
- Reset mid-frame: `uart_txd` returns to 1 on the reset edge, the frame is abandoned, and no `tx_done` is issued.
- `uart_txd` is driven from a flop; no combinational path to the pin.

## Timing
- Acceptance edge at cycle N: `uart_txd` falls at N+1.
- Frame length F = 1 + DATA_BITS + P + STOP_BITS bits, where P = 1 with parity, else 0.
- Transaction length: BYTES·F·BAUD_CNT cycles from the `uart_txd` fall.
- `tx_done` is high for exactly one cycle, which is the first IDLE cycle. `tx_ready` is also 1 in that cycle.
- A `tx_valid` held high is accepted in the `tx_done` cycle. This gives exactly one idle-high `sys_clk` cycle between transactions.

## Configuration
- Macro `UART_TX_PARITY_EN`:
  - Defined: a PAR state follows DATA. The parity bit is the XOR of the DATA_BITS data bits, inverted when `PARITY_ODD`=1.
  - Undefined: no PAR state, no parity logic, and `PARITY_ODD` is ignored.

## Test plan
All scenarios use `CLK_FRE`=50_000_000 and `BPS`=5_000_000, so BAUD_CNT=10.
- BYTES=2, DATA_BITS=8, STOP_BITS=1, no parity, `tx_data`=16'h1234 → 0x34 then 0x12. Line: 0,00101100,1,0,01001000,1, each bit 10 cycles. `tx_done` fires 200 cycles after the `uart_txd` fall.
- Same setup with MSB_BYTE_FIRST=1 → 0x12 first, then 0x34.
- Parity defined, BYTES=1, data 8'h34 (three ones):
  - PARITY_ODD=0 → parity bit 1.
  - PARITY_ODD=1 → parity bit 0.
  - Frame is 110 cycles.
- `tx_valid` held high with data 16'hAAAA then 16'h5555 →
  - the second word is accepted in the `tx_done` cycle;
  - exactly one high cycle separates the transactions;
  - `tx_data` changes mid-frame do not alter the output.
- Reset pulsed during the third data bit → next cycle `uart_txd`=1, `tx_ready`=1, no `tx_done`. A subsequent word transmits correctly.
- DATA_BITS=7, STOP_BITS=2, data 7'h41 → line 0,1000001,1,1. `tx_ready` stays low for all 100 cycles.
